// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
// PISO_PARITY_EN (optional define) appends an even-parity bit to every word.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake, bit strobe and serial output bundle for piso_serializer.
// master = word source / line consumer, slave = the serializer itself.
interface piso_serializer_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             en;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  modport master (
    output d, load_valid, en,
    input  load_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  d, load_valid, en,
    output load_ready, sout, sout_valid, busy, done
  );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Counts consumed bits of one word; saturates at WIDTH-1 and flags it as terminal.
module bit_counter #(
  parameter int WIDTH = 8,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign tc = (count_reg == CW'(WIDTH - 1));

  // clear wins over inc; saturation keeps the count inside one word
  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && !tc) begin
      count_next = count_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer: accepts a word in IDLE, emits one bit per en strobe, pulses done.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             done_reg;
  logic             done_next;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_tc;
  logic             sout_mux;
`ifdef PISO_PARITY_EN
  logic             parity_reg;
  logic             parity_next;
`endif

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    done_next   = 1'b0;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
`ifdef PISO_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.load_valid) begin
          shift_next  = bus.d;
          cnt_clear   = 1'b1;
          state_next  = SHIFT;
`ifdef PISO_PARITY_EN
          parity_next = ^bus.d;
`endif
        end
      end
      SHIFT: begin
        if (bus.en) begin
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          if (cnt_tc) begin
            // last data bit consumed; counter is parked at zero between words
            cnt_clear = 1'b1;
`ifdef PISO_PARITY_EN
            state_next = PARITY;
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (bus.en) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      done_reg   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      done_reg   <= done_next;
`ifdef PISO_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // line level is decoded from registered state only
  always_comb begin
    sout_mux = IDLE_LEVEL;
    case (state_reg)
      SHIFT:   sout_mux = shift_reg[WIDTH-1];
`ifdef PISO_PARITY_EN
      PARITY:  sout_mux = parity_reg;
`endif
      default: sout_mux = IDLE_LEVEL;
    endcase
  end

  assign bus.sout       = sout_mux;
  assign bus.load_ready = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.sout_valid = (state_reg != IDLE);
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed + random bench for piso_serializer against a bit-queue model of the serial line.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int WIDTH = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // model: bits still to appear on the line for the word in flight (empty = idle)
  bit   model_q[$];
  bit   model_done = 1'b0;

  piso_serializer_if #(.WIDTH(WIDTH)) bus ();

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_load(input logic [WIDTH-1:0] word);
    for (int i = WIDTH - 1; i >= 0; i--) model_q.push_back(word[i]);
`ifdef PISO_PARITY_EN
    model_q.push_back(^word);
`endif
  endtask

  // one clock: drive inputs, advance model on the edge, compare on the falling edge
  task automatic step(input logic rst, input logic lv, input logic [WIDTH-1:0] dv, input logic e);
    logic idle_exp;
    logic sout_exp;
    reset = rst;
    bus.load_valid = lv;
    bus.d = dv;
    bus.en = e;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (model_q.size() == 0) begin
        if (lv) begin
          model_load(dv);
          $display("cycle %0d: word %0h accepted", cyc, dv);
        end
      end else if (e) begin
        void'(model_q.pop_front());
        if (model_q.size() == 0) model_done = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
    idle_exp = (model_q.size() == 0);
    sout_exp = idle_exp ? 1'b1 : model_q[0];
    check("load_ready", 32'(bus.load_ready), 32'(idle_exp));
    check("sout",       32'(bus.sout),       32'(sout_exp));
    check("sout_valid", 32'(bus.sout_valid), 32'(!idle_exp));
    check("busy",       32'(bus.busy),       32'(!idle_exp));
    check("done",       32'(bus.done),       32'(model_done));
  endtask

  initial begin
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.d = '0;
    bus.en = 1'b0;

    // reset then idle, en toggling must not matter
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, i[0]);

    // A5 with en held high
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1);

    // 81 with en every third cycle
    step(1'b0, 1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 33; i++) step(1'b0, 1'b0, '0, (i % 3) == 2);

    // FF then 00 queued behind it with load_valid held high
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);

    // C3 cut by reset after four bits, then 3C
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1);

    // 55 offered while a word is in flight
    step(1'b0, 1'b1, 8'h96, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, (i == 2) || (i == 5), 8'h55, 1'b1);

    // random traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           WIDTH'($urandom()),
           $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer that drains the contents of an 8-bit holding register onto a single serial line, MSB first. Accepts a word over a valid/ready handshake, shifts one bit per bit-rate strobe, and signals completion. It is the read side of our parallel-load register path: registers capture words, this block reads them out serially.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; sampled on rising clk edge
- d  input  WIDTH  parallel word to serialize
- load_valid  input  1  word on d is offered
- load_ready  output  1  block can accept a word (high only in IDLE)
- en  input  1  bit-rate strobe; one serial bit consumed per cycle with en=1 in a shifting state
- sout  output  1  serial data; idle level 1
- sout_valid  output  1  sout carries a data/parity bit
- busy  output  1  word in flight (not IDLE)
- done  output  1  one-cycle pulse after the last bit is consumed

## Operation
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE: load_ready=1, sout=1, sout_valid=0, busy=0. Transfer occurs on a cycle with load_valid=1 and load_ready=1: d latched into shift register, bit counter cleared, next state SHIFT. en ignored in IDLE.
- SHIFT: sout = shift_reg[WIDTH-1], sout_valid=1, busy=1, load_ready=0. On en=1: shift left by one, counter+1. On the en tick that consumes bit WIDTH-1 (counter == WIDTH-1): go to PARITY if enabled, else IDLE with done=1 next cycle. en=0: hold everything.
- PARITY: sout = even parity (XOR) of the latched word, sout_valid=1. On en=1: go IDLE, done=1 next cycle.
- Counter width $clog2(WIDTH); never exceeds WIDTH-1; no wrap-around inside a word.
- load_valid while busy: ignored, word not accepted, no state change.
- Reset, including mid-word: next cycle IDLE, shift register and counter cleared, in-flight word discarded, done not pulsed.

## Timing
- Reset values: load_ready=1, sout=1, sout_valid=0, busy=0, done=0.
- All outputs registered or decoded from registered state; no combinational path d/load_valid/en → outputs.
- Load accepted at cycle N → first bit (d[WIDTH-1]) on sout at N+1.
- With en held high: data bits at N+1…N+WIDTH, done and load_ready=1 at N+WIDTH+1 (parity build: parity bit at N+WIDTH+1, done at N+WIDTH+2).
- done coincides with the first IDLE cycle; a new word may be accepted in that same cycle (back-to-back, one idle-level cycle between words).
- Each bit held on sout until the en tick that consumes it; bit duration = distance between en ticks.

## Configuration
- PISO_PARITY_EN defined: PARITY state compiled in; WIDTH+1 serial bits per word, last is even parity.
- Undefined: PARITY state and parity logic absent; WIDTH bits per word, SHIFT goes directly to IDLE.

## Structure
- Package piso_pkg: state enum typedef (IDLE, SHIFT, PARITY), IDLE_LEVEL=1'b1 constant, default WIDTH constant.
- One natural sub-module: bit_counter (enable-driven counter with synchronous clear and terminal-count flag at WIDTH-1); shift register and FSM stay in piso_serializer.

## Test plan
- Reset then idle 5 cycles -> load_ready=1, sout=1, sout_valid=0, busy=0, done=0 throughout.
- Load 8'hA5, en held high -> sout 1,0,1,0,0,1,0,1 on cycles N+1…N+8, done at N+9; with PISO_PARITY_EN parity bit 0 at N+9, done at N+10.
- Load 8'h81, en high every 3rd cycle -> each bit held exactly 3 cycles, sequence 1,0,0,0,0,0,0,1, single done pulse.
- load_valid held high with 8'hFF then 8'h00 queued -> second word accepted only on the done cycle; 8'h00 bits follow after one idle cycle; 8'hFF parity 0, 8'h00 parity 0.
- Load 8'hC3, assert reset after 4 bits -> IDLE next cycle, sout=1, no done pulse; subsequent 8'h3C serializes correctly from its MSB.
- load_valid pulsed while busy with 8'h55 -> ignored; current word's bits unchanged, only one done.
